// File: rtl/sys_mem_responder.sv
`default_nettype none
// -----------------------------------------------------------------------------
// sys_mem_responder: CVP14 word-addressed 16-bit memory, pipelined fixed-latency
// reads. Optional counters under SYSMEM_STATS_EN.        Rev 1.0
// -----------------------------------------------------------------------------
module sys_mem_responder #(
  parameter int AW     = 10,
  parameter int RD_LAT = 1
) (
  input  logic        Clk1,
  input  logic        Reset,
  input  logic [15:0] Addr,
  input  logic        RD,
  input  logic        WR,
  input  logic [15:0] WrData,
  output logic [15:0] RdData,
  output logic        RdValid,
  output logic        Err
`ifdef SYSMEM_STATS_EN
  ,output logic [15:0] RdCount
  ,output logic [15:0] WrCount
`endif
);

  localparam int unsigned DEPTH = 32'd1 << AW;

  logic [15:0] mem [DEPTH];
  logic        in_range;
  logic        issue;
  logic        wr_err;
  logic [15:0] rd_word;
  logic        tail_valid;
  logic        tail_oor;
  logic [15:0] tail_data;

  assign in_range = (32'(Addr) < DEPTH);
  // A collision is treated as a write; the read half is dropped.
  assign issue    = RD & ~WR;
  assign wr_err   = WR & (~in_range | RD);
  assign rd_word  = in_range ? mem[Addr[AW-1:0]] : 16'h0000;

  // Memory contents deliberately survive Reset.
  always_ff @(posedge Clk1) begin
    if (WR && in_range) begin
      mem[Addr[AW-1:0]] <= WrData;
    end
  end

  generate
    if (RD_LAT == 1) begin : g_lat1
      assign tail_valid = issue;
      assign tail_oor   = issue & ~in_range;
      assign tail_data  = rd_word;
    end else begin : g_latn
      logic [RD_LAT-2:0] pv;
      logic [RD_LAT-2:0] po;
      logic [15:0]       pd [RD_LAT-1];

      always_ff @(posedge Clk1 or posedge Reset) begin
        if (Reset) begin
          pv <= '0;
          po <= '0;
        end else begin
          pv[0] <= issue;
          po[0] <= issue & ~in_range;
          for (int i = 1; i < RD_LAT - 1; i++) begin
            pv[i] <= pv[i-1];
            po[i] <= po[i-1];
          end
        end
      end

      always_ff @(posedge Clk1) begin
        pd[0] <= rd_word;
        for (int i = 1; i < RD_LAT - 1; i++) begin
          pd[i] <= pd[i-1];
        end
      end

      assign tail_valid = pv[RD_LAT-2];
      assign tail_oor   = po[RD_LAT-2];
      assign tail_data  = pd[RD_LAT-2];
    end
  endgenerate

  always_ff @(posedge Clk1 or posedge Reset) begin
    if (Reset) begin
      RdData  <= 16'h0000;
      RdValid <= 1'b0;
      Err     <= 1'b0;
    end else begin
      RdValid <= tail_valid;
      if (tail_valid) begin
        RdData <= tail_data;
      end
      Err <= wr_err | (tail_valid & tail_oor);
    end
  end

`ifdef SYSMEM_STATS_EN
  always_ff @(posedge Clk1 or posedge Reset) begin
    if (Reset) begin
      RdCount <= 16'h0000;
      WrCount <= 16'h0000;
    end else begin
      if (issue && in_range && RdCount != 16'hFFFF) begin
        RdCount <= RdCount + 16'd1;
      end
      if (WR && in_range && WrCount != 16'hFFFF) begin
        WrCount <= WrCount + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire
